// File: rtl/vga_game_pkg.sv
// Shared definitions for the vga_game VRAM arbitration path.
//   AW_DEF / DW_DEF : default VRAM address / data widths
//   arb_state_t     : last issued VRAM slot (idle, display read, writer 0, writer 1)
//   W0 / W1         : writer indices, used for grant vectors and round-robin history
package vga_game_pkg;

  localparam int unsigned AW_DEF = 13;
  localparam int unsigned DW_DEF = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_DISP = 2'd1,
    ARB_W0   = 2'd2,
    ARB_W1   = 2'd3
  } arb_state_t;

  localparam logic W0 = 1'b0;
  localparam logic W1 = 1'b1;

endpackage

// File: rtl/vram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker, purely combinational.
//   req   [1:0] in  : eligible writer requests, indexed by W0 / W1
//   last        in  : writer granted most recently (W0 or W1)
//   grant [1:0] out : one-hot grant (all zero when req is zero)
// The round-robin history register lives in the parent.
module rr_arb2
  import vga_game_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (req[W0] && req[W1]) begin
      // Contention: the writer that did not win last time goes next.
      if (last == W1) begin
        grant[W0] = 1'b1;
      end else begin
        grant[W1] = 1'b1;
      end
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between the VGA display fetch
// (absolute priority) and two game-logic writers (round-robin on leftover slots).
//
// Ports:
//   CLK, RST                 : 100 MHz clock, asynchronous active-high reset
//   DISP_REQ / DISP_ADDR     : display read request pulse and address
//   DISP_VALID / DISP_DATA   : read data, two clocks after DISP_REQ
//   Wn_REQ/ADDR/DATA, Wn_ACK : writer n level request, one-cycle accept pulse
//   BLANK                    : high outside active video
//   MEM_ADDR/WDATA/WE        : registered RAM controls
//   MEM_RDATA                : RAM read data for the address presented last cycle
//
// Build option: define VRAM_ARB_BLANK_WR_EN to restrict writers to blanking
// (BLANK=1 at the sampling edge). Without it BLANK is ignored.
module vram_arbiter
  import vga_game_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          DISP_REQ,
  input  logic [AW-1:0] DISP_ADDR,
  output logic          DISP_VALID,
  output logic [DW-1:0] DISP_DATA,
  input  logic          W0_REQ,
  input  logic [AW-1:0] W0_ADDR,
  input  logic [DW-1:0] W0_DATA,
  output logic          W0_ACK,
  input  logic          W1_REQ,
  input  logic [AW-1:0] W1_ADDR,
  input  logic [DW-1:0] W1_DATA,
  output logic          W1_ACK,
  input  logic          BLANK,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  output logic          MEM_WE,
  input  logic [DW-1:0] MEM_RDATA
);

  arb_state_t r_state;
  logic       r_rr_last;

  logic       w_wr_ok;
  logic [1:0] w_elig;
  logic [1:0] w_grant;

`ifdef VRAM_ARB_BLANK_WR_EN
  assign w_wr_ok = BLANK;
`else
  // BLANK has no effect in this build; folded in only so the port is read.
  assign w_wr_ok = BLANK | 1'b1;
`endif

  // A writer is locked out for the slot right after its own grant, so a
  // still-high REQ (requester reacting to ACK) is not written twice.
  assign w_elig[W0] = W0_REQ && (r_state != ARB_W0) && w_wr_ok;
  assign w_elig[W1] = W1_REQ && (r_state != ARB_W1) && w_wr_ok;

  rr_arb2 u_rr (
    .req   (w_elig),
    .last  (r_rr_last),
    .grant (w_grant)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ARB_IDLE;
      r_rr_last  <= W1;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
      MEM_WE     <= 1'b0;
      DISP_VALID <= 1'b0;
      DISP_DATA  <= '0;
      W0_ACK     <= 1'b0;
      W1_ACK     <= 1'b0;
    end else begin
      W0_ACK <= 1'b0;
      W1_ACK <= 1'b0;

      // The previous slot was a display read: MEM_RDATA now holds its data.
      DISP_VALID <= (r_state == ARB_DISP);
      if (r_state == ARB_DISP) begin
        DISP_DATA <= MEM_RDATA;
      end

      if (DISP_REQ) begin
        r_state  <= ARB_DISP;
        MEM_ADDR <= DISP_ADDR;
        MEM_WE   <= 1'b0;
      end else if (w_grant[W0]) begin
        r_state   <= ARB_W0;
        r_rr_last <= W0;
        MEM_ADDR  <= W0_ADDR;
        MEM_WDATA <= W0_DATA;
        MEM_WE    <= 1'b1;
        W0_ACK    <= 1'b1;
      end else if (w_grant[W1]) begin
        r_state   <= ARB_W1;
        r_rr_last <= W1;
        MEM_ADDR  <= W1_ADDR;
        MEM_WDATA <= W1_DATA;
        MEM_WE    <= 1'b1;
        W1_ACK    <= 1'b1;
      end else begin
        r_state <= ARB_IDLE;
        MEM_WE  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
`timescale 1ns/1ps
module tb_vram_arbiter;

  localparam int AW = 13;
  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          DISP_REQ;
  logic [AW-1:0] DISP_ADDR;
  logic          DISP_VALID;
  logic [DW-1:0] DISP_DATA;
  logic          wreq  [2];
  logic [AW-1:0] waddr [2];
  logic [DW-1:0] wdata [2];
  logic          W0_ACK, W1_ACK;
  logic          BLANK;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA;
  logic          MEM_WE;
  logic [DW-1:0] MEM_RDATA;

  always #5 CLK = ~CLK;

  vram_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST),
    .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR),
    .DISP_VALID(DISP_VALID), .DISP_DATA(DISP_DATA),
    .W0_REQ(wreq[0]), .W0_ADDR(waddr[0]), .W0_DATA(wdata[0]), .W0_ACK(W0_ACK),
    .W1_REQ(wreq[1]), .W1_ADDR(waddr[1]), .W1_DATA(wdata[1]), .W1_ACK(W1_ACK),
    .BLANK(BLANK),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE),
    .MEM_RDATA(MEM_RDATA)
  );

  // RAM: data for the registered address is available before the next edge.
  logic [DW-1:0] ram    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  assign MEM_RDATA = ram[MEM_ADDR];
  always @(posedge CLK) if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            wr;
  } exp_t;

  exp_t q_wr[$];
  exp_t q_rd[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   n_w1_ack = 0;

  // Reference model state: who was served in the previous slot, and which
  // writer won the most recent writer slot.
  int   m_prev_writer;
  int   m_rr_last;
  bit   granted [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    q_wr.delete();
    q_rd.delete();
    m_prev_writer = -1;
    m_rr_last     = 1;
    granted[0]    = 1'b0;
    granted[1]    = 1'b0;
  endtask

  task automatic model_eval();
    bit elig [2];
    bit blank_ok;
    int win;
    granted[0] = 1'b0;
    granted[1] = 1'b0;
`ifdef VRAM_ARB_BLANK_WR_EN
    blank_ok = BLANK;
`else
    blank_ok = 1'b1;
`endif
    if (DISP_REQ) begin
      q_rd.push_back('{cyc + 1, DISP_ADDR, shadow[DISP_ADDR], -1});
      m_prev_writer = -1;
      return;
    end
    for (int n = 0; n < 2; n++) elig[n] = wreq[n] && (m_prev_writer != n) && blank_ok;
    if (elig[0] && elig[1]) win = 1 - m_rr_last;
    else if (elig[0])       win = 0;
    else if (elig[1])       win = 1;
    else                    win = -1;
    m_prev_writer = win;
    if (win >= 0) begin
      m_rr_last = win;
      granted[win] = 1'b1;
      q_wr.push_back('{cyc, waddr[win], wdata[win], win});
      shadow[waddr[win]] = wdata[win];
    end
  endtask

  // One clock: model samples inputs at the edge, caller drives new inputs after.
  task automatic step();
    @(posedge CLK);
    cyc++;
    if (RST) model_reset();
    else     model_eval();
    #1;
  endtask

  // Monitor: compares DUT outputs against expectations queued by the model.
  always @(negedge CLK) begin
    exp_t e;
    bit   exp_we, exp_v;
    if (!RST) begin
      exp_we = (q_wr.size() > 0) && (q_wr[0].cyc == cyc);
      chk("mem_we", MEM_WE, exp_we);
      if (exp_we) begin
        e = q_wr.pop_front();
        chk("wr_addr", MEM_ADDR, e.addr);
        chk("wr_data", MEM_WDATA, e.data);
        chk("w0_ack", W0_ACK, (e.wr == 0));
        chk("w1_ack", W1_ACK, (e.wr == 1));
      end else begin
        chk("w0_ack_idle", W0_ACK, 0);
        chk("w1_ack_idle", W1_ACK, 0);
      end
      if (W1_ACK) n_w1_ack++;
      exp_v = (q_rd.size() > 0) && (q_rd[0].cyc == cyc);
      chk("disp_valid", DISP_VALID, exp_v);
      if (exp_v) begin
        e = q_rd.pop_front();
        chk("disp_data", DISP_DATA, e.data);
      end
      if (q_rd.size() > 0 && q_rd[0].cyc == cyc + 1) chk("rd_addr", MEM_ADDR, q_rd[0].addr);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_addr"}, MEM_ADDR, 0);
    chk({tag, "_mem_wdata"}, MEM_WDATA, 0);
    chk({tag, "_mem_we"}, MEM_WE, 0);
    chk({tag, "_disp_valid"}, DISP_VALID, 0);
    chk({tag, "_disp_data"}, DISP_DATA, 0);
    chk({tag, "_w0_ack"}, W0_ACK, 0);
    chk({tag, "_w1_ack"}, W1_ACK, 0);
  endtask

  initial begin
    int cooldown;
    int ack_before;
    logic [DW-1:0] v;

    RST = 1'b1; DISP_REQ = 1'b0; DISP_ADDR = '0; BLANK = 1'b0;
    for (int n = 0; n < 2; n++) begin wreq[n] = 1'b0; waddr[n] = '0; wdata[n] = '0; end
    for (int unsigned i = 0; i < 64; i++) begin
      v = 16'($urandom);
      ram[i] <= v;
      shadow[i] = v;
    end
    ram[13'h0123] <= 16'hBEEF;
    shadow[13'h0123] = 16'hBEEF;
    model_reset();
    repeat (3) step();
    chk_all_zero("reset");
    RST = 1'b0;
    step();

    // Read in flight when reset hits: dropped, outputs cleared.
    DISP_REQ = 1'b1; DISP_ADDR = 13'h0010;
    step();
    DISP_REQ = 1'b0;
    RST = 1'b1;
    model_reset();
    #2;
    chk_all_zero("rst_mid_read");
    repeat (3) step();
    chk_all_zero("rst_hold");
    RST = 1'b0;
    repeat (4) step();

    // Display read of a preloaded word.
    DISP_REQ = 1'b1; DISP_ADDR = 13'h0123;
    step();
    DISP_REQ = 1'b0;
    repeat (4) step();

    // Display and writer collide: display first, writer next slot.
    DISP_REQ = 1'b1; DISP_ADDR = 13'h0001;
    wreq[0] = 1'b1; waddr[0] = 13'h0002; wdata[0] = 16'h1111;
    step();
    DISP_REQ = 1'b0;
    step();
    wreq[0] = 1'b0;
    repeat (4) step();

    // Both writers held from reset: strict alternation starting with W0.
    RST = 1'b1;
    step();
    for (int n = 0; n < 2; n++) begin
      wreq[n] = 1'b1; waddr[n] = 13'(8 + n); wdata[n] = 16'($urandom);
    end
    RST = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      for (int n = 0; n < 2; n++) if (granted[n]) wdata[n] = 16'($urandom);
    end
    wreq[0] = 1'b0; wreq[1] = 1'b0;
    repeat (3) step();

    // Lockout: single writer holds REQ, swaps data on ACK.
    wreq[0] = 1'b1; waddr[0] = 13'h0005; wdata[0] = 16'hAAAA;
    step();
    wdata[0] = 16'h5555;
    step();
    step();
    wreq[0] = 1'b0;
    repeat (3) step();
    DISP_REQ = 1'b1; DISP_ADDR = 13'h0005;
    step();
    DISP_REQ = 1'b0;
    repeat (4) step();

    // BLANK gating of writers.
    BLANK = 1'b0;
    wreq[1] = 1'b1; waddr[1] = 13'h0007; wdata[1] = 16'h7777;
    ack_before = n_w1_ack;
    for (int k = 0; k < 20; k++) begin
      step();
      if (granted[1]) wreq[1] = 1'b0;
    end
`ifdef VRAM_ARB_BLANK_WR_EN
    chk("blank_low_acks", n_w1_ack - ack_before, 0);
`else
    chk("blank_low_acks", n_w1_ack - ack_before, 1);
`endif
    BLANK = 1'b1;
    repeat (3) begin
      step();
      if (granted[1]) wreq[1] = 1'b0;
    end
    wreq[1] = 1'b0;
    step();
    chk("blank_total_acks", n_w1_ack - ack_before, 1);

    // Randomized traffic.
    cooldown = 0;
    for (int k = 0; k < 3000; k++) begin
      step();
      DISP_REQ = 1'b0;
      if (cooldown > 0) cooldown--;
      else if ($urandom_range(0, 2) == 0) begin
        DISP_REQ = 1'b1;
        DISP_ADDR = 13'($urandom_range(0, 63));
        cooldown = 3;
      end
      for (int n = 0; n < 2; n++) begin
        if (granted[n]) begin
          if ($urandom_range(0, 1) == 0) wreq[n] = 1'b0;
          else begin waddr[n] = 13'($urandom_range(0, 63)); wdata[n] = 16'($urandom); end
        end else if (wreq[n]) begin
          if ($urandom_range(0, 19) == 0) wreq[n] = 1'b0;
        end else if ($urandom_range(0, 9) < 3) begin
          wreq[n] = 1'b1; waddr[n] = 13'($urandom_range(0, 63)); wdata[n] = 16'($urandom);
        end
      end
      if ($urandom_range(0, 15) == 0) BLANK = ~BLANK;
    end
    DISP_REQ = 1'b0; wreq[0] = 1'b0; wreq[1] = 1'b0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
